// File: rtl/clock_ctl.sv
// Front-panel run/step sequencer driving auton/m of the CPU clock generator.
// Optional burst stepping: define CLOCK_CTL_BURST_EN.
module clock_ctl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int M_LOW_CYCLES    = 8,
  parameter int STEP_TIMEOUT    = 255,
  parameter int STEP_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              hlt,
  input  logic              cpu_clk,
  input  logic [STEP_W-1:0] step_count,
  output logic              auton,
  output logic              m,
  output logic              running,
  output logic              halted,
  output logic              busy,
  output logic              step_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_HALTED, S_STEP_HI, S_STEP_LO
  } state_e;

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (STEP_TIMEOUT > M_LOW_CYCLES) ?
                        STEP_TIMEOUT : M_LOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // bit 0 run, 1 step, 2 hlt, 3 cpu_clk
  logic [3:0] s1_q, s2_q;

  logic [1:0]         db_q, db_d;
  logic [1:0][DW-1:0] dbc_q, dbc_d;
  logic [1:0]         press;

  logic          cpu_prev_q;
  logic          cpu_rise;
  logic          hlt_s;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo;
  logic          rem_nz;

  logic auton_q, m_q, running_q, halted_q, busy_q, step_err_q;

`ifdef CLOCK_CTL_BURST_EN
  logic [STEP_W-1:0] rem_q, rem_d;
  assign rem_nz = (rem_q != '0);
`else
  logic unused_step_count;
  assign unused_step_count = ^step_count;
  assign rem_nz = 1'b0;
`endif

  assign hlt_s    = s2_q[2];
  assign cpu_rise = s2_q[3] & ~cpu_prev_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      dbc_d[i] = '0;
      press[i] = 1'b0;
      if (s2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]  = ~db_q[i];
          press[i] = ~db_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
`ifdef CLOCK_CTL_BURST_EN
    rem_d   = rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (press[0]) begin
          state_d = S_RUN;
        end else if (press[1]) begin
          state_d = S_STEP_HI;
`ifdef CLOCK_CTL_BURST_EN
          rem_d = (step_count == '0) ? STEP_W'(1) : step_count;
`endif
        end
      end
      S_RUN: begin
        if (hlt_s) state_d = S_HALTED;
        else if (press[0]) state_d = S_IDLE;
      end
      S_HALTED: begin
        if (press[0] && !hlt_s) begin
          state_d = S_RUN;
        end else if (press[1]) begin
          state_d = S_STEP_HI;
`ifdef CLOCK_CTL_BURST_EN
          rem_d = (step_count == '0) ? STEP_W'(1) : step_count;
`endif
        end
      end
      S_STEP_HI: begin
        if (cpu_rise) begin
          state_d = S_STEP_LO;
`ifdef CLOCK_CTL_BURST_EN
          rem_d = rem_q - 1'b1;
`endif
        end else if (tmr_q == TW'(STEP_TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
`ifdef CLOCK_CTL_BURST_EN
          rem_d = '0;
`endif
        end
      end
      S_STEP_LO: begin
        if (tmr_q == TW'(M_LOW_CYCLES - 1)) begin
          if (rem_nz && !hlt_s) state_d = S_STEP_HI;
          else if (hlt_s)       state_d = S_HALTED;
          else                  state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shared timer: restarts on any state change, saturates otherwise
  always_comb begin
    tmr_d = (tmr_q == TW'(TMAX)) ? tmr_q : tmr_q + 1'b1;
    if (state_d != state_q) tmr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      db_q       <= '0;
      dbc_q      <= '0;
      cpu_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      auton_q    <= 1'b1;
      m_q        <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      s1_q       <= {cpu_clk, hlt, btn_step, btn_run};
      s2_q       <= s1_q;
      db_q       <= db_d;
      dbc_q      <= dbc_d;
      cpu_prev_q <= s2_q[3];
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      auton_q    <= (state_d != S_RUN);
      m_q        <= (state_d == S_STEP_HI);
      running_q  <= (state_d == S_RUN);
      halted_q   <= (state_d == S_HALTED);
      busy_q     <= (state_d == S_STEP_HI) ||
                    (state_d == S_STEP_LO);
      step_err_q <= tmo;
    end
  end

`ifdef CLOCK_CTL_BURST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end
`endif

  assign auton    = auton_q;
  assign m        = m_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign busy     = busy_q;
  assign step_err = step_err_q;

endmodule
